// File: rtl/digest_collector.sv
// Collects a serial LSB-first digest from a hash core into an L-bit word and
// holds it, together with a registered comparison against a reference, until acknowledged.
module digest_collector #(
    parameter int L = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         digest_readyxSI,
    input  logic         digest_bitxSI,
    input  logic [L-1:0] expectedxDI,
    input  logic         readxSI,
    output logic [L-1:0] digestxDO,
    output logic         validxSO,
    output logic         matchxSO,
    output logic         busyxSO,
    output logic         abortxSO
);

    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE,
        DRAIN
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [L-1:0]  digest_q;
    logic          valid_q;
    logic          match_q;
    logic          busy_q;
    logic          abort_q;

    logic [L-1:0]  digest_d;
    logic          last_bit_d;

    // New bit enters at the MSB; after L shifts serial bit k sits at index k.
    always_comb begin
        digest_d   = {digest_bitxSI, digest_q[L-1:1]};
        last_bit_d = (cnt_q == CW'(L - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digest_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (digest_readyxSI) begin
                        state_q <= CAPTURE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                // A dropped ready wins over the final bit.
                CAPTURE: begin
                    if (!digest_readyxSI) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end else begin
                        digest_q <= digest_d;
                        cnt_q    <= cnt_q + 1'b1;
                        if (last_bit_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            match_q <= (digest_d == expectedxDI);
                        end
                    end
                end

                DONE: begin
                    if (readxSI) begin
                        valid_q <= 1'b0;
                        match_q <= 1'b0;
                        state_q <= digest_readyxSI ? DRAIN : IDLE;
                    end
                end

                // Wait for ready to fall so the static tail is not recaptured.
                DRAIN: begin
                    if (!digest_readyxSI) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign digestxDO = digest_q;
    assign validxSO  = valid_q;
    assign matchxSO  = match_q;
    assign busyxSO   = busy_q;
    assign abortxSO  = abort_q;

endmodule

// File: tb/tb_digest_collector.sv
// Self-checking bench for digest_collector: an 8-bit and a 256-bit instance
// exercised with directed and randomized serial captures.
module tb_digest_collector;

    logic         clk = 1'b0;
    logic         rst;

    logic         readyA, bitA, readA;
    logic [7:0]   expA, digestA;
    logic         validA, matchA, busyA, abortA;

    logic         readyB, bitB, readB;
    logic [255:0] expB, digestB;
    logic         validB, matchB, busyB, abortB;

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    digest_collector #(.L(8)) dutA (
        .clk(clk), .rst(rst),
        .digest_readyxSI(readyA), .digest_bitxSI(bitA),
        .expectedxDI(expA), .readxSI(readA),
        .digestxDO(digestA), .validxSO(validA), .matchxSO(matchA),
        .busyxSO(busyA), .abortxSO(abortA)
    );

    digest_collector #(.L(256)) dutB (
        .clk(clk), .rst(rst),
        .digest_readyxSI(readyB), .digest_bitxSI(bitB),
        .expectedxDI(expB), .readxSI(readB),
        .digestxDO(digestB), .validxSO(validB), .matchxSO(matchB),
        .busyxSO(busyB), .abortxSO(abortB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full 8-bit capture from IDLE; word[k] is the k-th serial bit.
    task automatic capture8(input logic [7:0] word, input logic [7:0] expWord, input string name);
        logic [7:0] model;
        model = '0;
        for (int k = 0; k < 8; k++) model = model | (8'(word[k]) << k);
        expA   = expWord;
        readyA = 1'b1;
        tick();
        vecCount++;
        if (busyA !== 1'b1 || validA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL %s start busy/valid got %b%b want 10", name, busyA, validA);
        end
        for (int k = 0; k < 8; k++) begin
            bitA = word[k];
            tick();
            if (k < 7) begin
                vecCount++;
                if (busyA !== 1'b1 || validA !== 1'b0) begin
                    errCount++;
                    $display("[TB] FAIL %s bit%0d busy/valid got %b%b want 10", name, k, busyA, validA);
                end
            end
        end
        vecCount++;
        if (validA !== 1'b1 || busyA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL %s done valid/busy got %b%b want 10", name, validA, busyA);
        end
        vecCount++;
        if (digestA !== model) begin
            errCount++;
            $display("[TB] FAIL %s digest got %h want %h", name, digestA, model);
        end
        vecCount++;
        if (matchA !== (model == expWord)) begin
            errCount++;
            $display("[TB] FAIL %s match got %b want %b", name, matchA, (model == expWord));
        end
    endtask

    // Acknowledges the held digest with ready low, returning the block to IDLE.
    task automatic release8(input logic [7:0] held, input string name);
        readA  = 1'b1;
        readyA = 1'b0;
        tick();
        readA = 1'b0;
        vecCount++;
        if (validA !== 1'b0 || matchA !== 1'b0 || busyA !== 1'b0 || digestA !== held) begin
            errCount++;
            $display("[TB] FAIL %s release v/m/b/digest got %b%b%b %h want 000 %h",
                     name, validA, matchA, busyA, digestA, held);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        readyA = 1'b1; bitA = 1'b1; readA = 1'b1; expA = '1;
        readyB = 1'b1; bitB = 1'b1; readB = 1'b1; expB = '1;
        tick();
        tick();
        vecCount++;
        if ({digestA, validA, matchA, busyA, abortA} !== '0) begin
            errCount++;
            $display("[TB] FAIL reset_A got %h %b%b%b%b want all zero", digestA, validA, matchA, busyA, abortA);
        end
        vecCount++;
        if ({digestB, validB, matchB, busyB, abortB} !== '0) begin
            errCount++;
            $display("[TB] FAIL reset_B got valid/match/busy/abort %b%b%b%b want 0000", validB, matchB, busyB, abortB);
        end
        readyA = 1'b0; readA = 1'b0; bitA = 1'b0; expA = '0;
        readyB = 1'b0; readB = 1'b0; bitB = 1'b0; expB = '0;
        rst = 1'b1;
        tick();
        tick();
        vecCount++;
        if (busyA !== 1'b0 || busyB !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_release busy got %b%b want 00", busyA, busyB);
        end
    endtask

    task automatic test_capture_match();
        logic       serial [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] word;
        for (int k = 0; k < 8; k++) word[k] = serial[k];
        capture8(word, 8'h4D, "match_4D");
        vecCount++;
        if (digestA !== 8'h4D || matchA !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL match_4D const got %h/%b want 4d/1", digestA, matchA);
        end
        release8(8'h4D, "match_4D");
    endtask

    task automatic test_mismatch_hold();
        capture8(8'h4D, 8'h4C, "mismatch_4C");
        expA = 8'h4D;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecCount++;
            if (validA !== 1'b1 || matchA !== 1'b0 || digestA !== 8'h4D) begin
                errCount++;
                $display("[TB] FAIL hold_done got v/m %b%b digest %h want 10 4d", validA, matchA, digestA);
            end
        end
        release8(8'h4D, "mismatch_4C");
    endtask

    task automatic test_abort();
        readyA = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            bitA = 1'($urandom);
            tick();
        end
        readyA = 1'b0;
        tick();
        vecCount++;
        if (abortA !== 1'b1 || validA !== 1'b0 || busyA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL abort5 a/v/b got %b%b%b want 100", abortA, validA, busyA);
        end
        tick();
        vecCount++;
        if (abortA !== 1'b0 || validA !== 1'b0 || busyA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL abort5_after a/v/b got %b%b%b want 000", abortA, validA, busyA);
        end
        capture8(8'hA5, 8'hA5, "after_abort_A5");
        release8(8'hA5, "after_abort_A5");

        // Ready drops on the very edge that would sample the last bit.
        readyA = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            bitA = 1'b1;
            tick();
        end
        readyA = 1'b0;
        tick();
        vecCount++;
        if (abortA !== 1'b1 || validA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL abort_last a/v got %b%b want 10", abortA, validA);
        end
        tick();
        vecCount++;
        if (abortA !== 1'b0 || validA !== 1'b0 || busyA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL abort_last_after a/v/b got %b%b%b want 000", abortA, validA, busyA);
        end
    endtask

    task automatic test_reset_mid_capture();
        logic [7:0] word;
        readyA = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            bitA = 1'b1;
            tick();
        end
        rst = 1'b0;
        tick();
        vecCount++;
        if ({digestA, validA, matchA, busyA, abortA} !== '0) begin
            errCount++;
            $display("[TB] FAIL reset_mid got %h %b%b%b%b want all zero", digestA, validA, matchA, busyA, abortA);
        end
        rst = 1'b1;
        word = 8'($urandom);
        capture8(word, word, "restart_after_reset");
        release8(word, "restart_after_reset");
    endtask

    task automatic test_read_ignored();
        logic [7:0] word;
        readA = 1'b1;
        readyA = 1'b0;
        tick();
        tick();
        vecCount++;
        if (validA !== 1'b0 || busyA !== 1'b0 || abortA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL read_idle v/b/a got %b%b%b want 000", validA, busyA, abortA);
        end
        word = 8'($urandom);
        capture8(word, ~word, "read_in_capture");
        readA = 1'b0;
        tick();
        vecCount++;
        if (validA !== 1'b1 || matchA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL read_in_capture hold v/m got %b%b want 10", validA, matchA);
        end
        release8(word, "read_in_capture");
    endtask

    // Random words and references, random hold times and random ready level at acknowledge.
    task automatic test_back_to_back();
        logic [7:0] word, expWord;
        logic       wantMatch, readyAtRead;
        for (int i = 0; i < 24; i++) begin
            word = 8'($urandom);
            expWord = ($urandom_range(0, 1) == 1) ? word : 8'($urandom);
            wantMatch = (word == expWord);
            capture8(word, expWord, "random");
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                expA = 8'($urandom);
                tick();
                vecCount++;
                if (validA !== 1'b1 || matchA !== wantMatch) begin
                    errCount++;
                    $display("[TB] FAIL random_hold #%0d v/m got %b%b want 1%b", i, validA, matchA, wantMatch);
                end
            end
            readyAtRead = 1'($urandom);
            readA  = 1'b1;
            readyA = readyAtRead;
            tick();
            readA = 1'b0;
            vecCount++;
            if (validA !== 1'b0 || matchA !== 1'b0 || digestA !== word) begin
                errCount++;
                $display("[TB] FAIL random_read #%0d v/m/digest got %b%b %h want 00 %h", i, validA, matchA, digestA, word);
            end
            if (readyAtRead) begin
                for (int d = 0; d < int'($urandom_range(1, 4)); d++) begin
                    bitA = 1'($urandom);
                    tick();
                    vecCount++;
                    if (busyA !== 1'b0 || validA !== 1'b0) begin
                        errCount++;
                        $display("[TB] FAIL drain #%0d busy/valid got %b%b want 00", i, busyA, validA);
                    end
                end
                readyA = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_long256();
        logic [255:0] model;
        int           edges;
        readyB = 1'b1; bitB = 1'b1; readB = 1'b0; expB = '1;
        edges = 0;
        do begin
            tick();
            edges++;
        end while (validB !== 1'b1 && edges < 400);
        vecCount++;
        if (edges != 257) begin
            errCount++;
            $display("[TB] FAIL long_latency got %0d edges want 257", edges);
        end
        vecCount++;
        if (digestB !== {256{1'b1}} || matchB !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL long_ones digest ones=%b match got %b want 1/1", (digestB === {256{1'b1}}), matchB);
        end
        for (int i = 0; i < 10; i++) tick();
        vecCount++;
        if (validB !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL long_hold valid got %b want 1", validB);
        end
        readB = 1'b1;
        tick();
        readB = 1'b0;
        vecCount++;
        if (validB !== 1'b0 || matchB !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL long_read v/m got %b%b want 00", validB, matchB);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            vecCount++;
            if (busyB !== 1'b0 || validB !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL long_drain cycle %0d busy/valid got %b%b want 00", i, busyB, validB);
            end
        end
        readyB = 1'b0;
        tick();
        readyB = 1'b1;
        tick();
        vecCount++;
        if (busyB !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL long_recapture busy got %b want 1", busyB);
        end
        for (int w = 0; w < 8; w++) model[w*32 +: 32] = $urandom;
        expB = model;
        for (int k = 0; k < 256; k++) begin
            bitB = model[k];
            tick();
        end
        vecCount++;
        if (validB !== 1'b1 || digestB !== model || matchB !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL long_random v/m got %b%b digest_ok %b want 1 1 1", validB, matchB, (digestB === model));
        end
        readB = 1'b1;
        readyB = 1'b0;
        tick();
        readB = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture_match();
        test_mismatch_hold();
        test_abort();
        test_reset_mid_capture();
        test_read_ignored();
        test_back_to_back();
        test_long256();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/digest_collector.md
DIGEST_COLLECTOR -- requirements
Module: digest_collector

Interface
REQ-001 The block SHALL have parameter L, default 256, meaning the digest length in bits; legal range 8..1024.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port digest_readyxSI  input  1  the upstream hash-ready level; stays high once the digest is available.
REQ-005 The block SHALL have port digest_bitxSI  input  1  the serial digest bit from the hash core, LSB first, one bit per cycle.
REQ-006 The block SHALL have port expectedxDI  input  L  the reference digest for comparison.
REQ-007 The block SHALL have port readxSI  input  1  the consumer acknowledge for the held digest.
REQ-008 The block SHALL have port digestxDO  output  L  the assembled digest, bit k equal to serial bit k.
REQ-009 The block SHALL have port validxSO  output  1  high while a complete digest is held.
REQ-010 The block SHALL have port matchxSO  output  1  high while validxSO is high, when the held digest equals expectedxDI.
REQ-011 The block SHALL have port busyxSO  output  1  high in CAPTURE.
REQ-012 The block SHALL have port abortxSO  output  1  a one-cycle pulse when a capture is aborted.

Function
REQ-013 The block SHALL implement four states: IDLE, CAPTURE, DONE and DRAIN, with all outputs registered.
REQ-014 IDLE -> CAPTURE SHALL occur on the first edge (t0) that samples digest_readyxSI=1 in IDLE; the bit counter is cleared to 0 on that edge.
REQ-015 In CAPTURE, each edge SHALL sample digest_bitxSI into digestxDO[counter] and increment the counter, so bit k is sampled at edge t0+1+k.
REQ-016 The capture implementation SHALL be a right shift with the new bit inserted at the MSB, or an indexed write; either is acceptable provided the result is bit-exact.
REQ-017 CAPTURE -> DONE SHALL occur on the edge that samples bit L-1 (edge t0+L).
REQ-018 On the edge of REQ-017, validxSO SHALL go high and matchxSO SHALL be registered as the full-word equality of the assembled digest against expectedxDI sampled on that edge.
REQ-019 The total latency SHALL be L+1 edges from digest_readyxSI being sampled high to validxSO high.
REQ-020 In DONE, digestxDO, validxSO and matchxSO SHALL hold; expectedxDI changes in DONE SHALL NOT alter matchxSO.
REQ-021 In DONE with readxSI=1, the block SHALL clear validxSO and matchxSO on that edge.
REQ-022 The next state after REQ-021 SHALL be DRAIN if digest_readyxSI=1, else IDLE; digestxDO SHALL retain its value.
REQ-023 In DONE with readxSI=0, the block SHALL remain in DONE indefinitely.
REQ-024 In DRAIN, the block SHALL ignore digest_bitxSI and SHALL return to IDLE on the first edge that samples digest_readyxSI=0; this prevents recapture of the static tail bit.
REQ-025 If CAPTURE samples digest_readyxSI=0 before bit L-1, the block SHALL go to IDLE, pulse abortxSO for one cycle, keep validxSO low, and leave the partial digestxDO content undefined.
REQ-026 readxSI in any state other than DONE SHALL be ignored.
REQ-027 The counter SHALL be ceil(log2(L+1)) bits wide and SHALL never wrap within a capture.
REQ-028 If the abort condition and bit L-1 fall on the same edge, the abort SHALL take priority.

Reset
REQ-029 rst=0 sampled on any edge SHALL force IDLE, counter=0, digestxDO=0, validxSO=0, matchxSO=0, busyxSO=0 and abortxSO=0, regardless of state, including mid-CAPTURE.
REQ-030 While rst=0, all other inputs SHALL be ignored.
REQ-031 The first capture after reset release SHALL require digest_readyxSI sampled high in IDLE.

Verification
REQ-032 L=8, ready high at t0, serial bits 1,0,1,1,0,0,1,0 -> busyxSO high t0..t0+7, validxSO high after t0+8, digestxDO=8'h4D, expectedxDI=8'h4D -> matchxSO=1.
REQ-033 Same stimulus with expectedxDI=8'h4C -> validxSO=1, matchxSO=0; changing expectedxDI to 8'h4D while in DONE -> matchxSO stays 0.
REQ-034 L=256, upstream Hashing core producing all-ones digest, readxSI held 0 -> validxSO high exactly 257 edges after ready sampled, held while readxSI=0; readxSI=1 with ready still high -> DRAIN, no recapture until ready low then high again.
REQ-035 L=8, ready dropped after 5 bits -> abortxSO one-cycle pulse, validxSO stays 0, state IDLE; a fresh capture of 8'hA5 then completes correctly.
REQ-036 rst=0 asserted at bit 3 of a capture -> next edge all outputs 0 and IDLE; release with ready high -> a full capture restarts from bit 0.
REQ-037 readxSI pulsed in IDLE and in CAPTURE -> no effect on state or outputs.
